ram40_stream_fifo: RTL and testbench
====================================

# ram40_stream_fifo

Single-clock, first-word-fall-through stream FIFO controller that drives the write and read ports of one externally instantiated SB_RAM40_4K. The RAM runs in READ_MODE 0 / WRITE_MODE 0 (256 x 16). The block sits directly upstream and downstream of the RAM: it turns a valid/ready input stream into RAM write cycles and RAM read data into a valid/ready output stream. A 2-entry output buffer hides the RAM's one-cycle read latency.

## Interface
- ALMOST_FULL_LVL, 240: LEVEL threshold for ALMOST_FULL (legal 1..258).
- CLK  in  1  single clock; also tied externally to RAM WCLK and RCLK.
- RESETN  in  1  reset, asynchronous assert, active low.
- IN_DATA  in  16  input word.
- IN_VALID  in  1  input word present.
- IN_READY  out  1  block accepts IN_DATA this cycle.
- OUT_DATA  out  16  head-of-FIFO word.
- OUT_VALID  out  1  OUT_DATA holds a valid word.
- OUT_READY  in  1  consumer takes OUT_DATA this cycle.
- LEVEL  out  9  total stored words, 0..258.
- ALMOST_FULL  out  1  LEVEL >= ALMOST_FULL_LVL.
- RAM_WADDR  out  11  {3'b000, wptr[7:0]}.
- RAM_WDATA  out  16  equal to IN_DATA.
- RAM_MASK  out  16  constant 16'h0000 (all bits written).
- RAM_WE, RAM_WCLKE  out  1 each  both equal to push.
- RAM_RADDR  out  11  {3'b000, rptr[7:0]}.
- RAM_RE, RAM_RCLKE  out  1 each  both equal to rd_issue.
- RAM_RDATA  in  16  RAM read data, valid the cycle after a read issue.

## Operation
- State:
  - wptr[7:0] and rptr[7:0] address the RAM and wrap 255 -> 0.
  - ram_cnt (0..256) counts words written to the RAM but not yet read-issued.
  - inflight (1 bit) is high the cycle after a read issue.
  - obuf is a 2-entry FIFO with out_cnt 0..2; its head drives OUT_DATA.
- Fire conditions:
  - push = IN_VALID && IN_READY; IN_READY = RESETN && ram_cnt != 256.
  - pop = OUT_VALID && OUT_READY; OUT_VALID = out_cnt != 0.
  - rd_issue = RESETN && ram_cnt != 0 && (out_cnt + inflight - pop) < 2.
- Per clock edge:
  - On push: RAM writes IN_DATA at wptr; wptr increments.
  - On rd_issue: rptr increments; inflight is set to 1, otherwise cleared.
  - When inflight is 1: RAM_RDATA is appended to obuf. This happens in the same edge as any pop, and pop removes the head first.
  - ram_cnt += push - rd_issue. out_cnt += inflight - pop.
- LEVEL = ram_cnt + inflight + out_cnt, registered. Maximum is 258: 256 in the RAM plus 2 in obuf.
- Read/write collision is impossible: a read needs ram_cnt > 0 and a write needs ram_cnt < 256, so within a cycle RAM_RADDR != RAM_WADDR.
- Ordering is strict FIFO across pointer wrap-around. No word is dropped or duplicated.
- Push while full is not accepted (IN_READY = 0). Pop while empty is ignored (OUT_VALID = 0).
- Simultaneous push and pop are always permitted when each side is individually enabled.

## Timing
- Reset (RESETN low, asynchronous):
  - wptr = rptr = 0, ram_cnt = 0, inflight = 0, out_cnt = 0.
  - OUT_VALID = 0, LEVEL = 0, ALMOST_FULL = 0.
  - IN_READY, RAM_WE and RAM_RE are forced to 0 while RESETN is low.
  - obuf data is don't-care.
- Reset mid-operation discards all contents. RAM contents are not cleared but are unreachable.
- Latency into an empty FIFO:
  - Push accepted at edge E0.
  - rd_issue is high in the cycle after E0 and takes effect at E1.
  - Word is captured into obuf at E2; OUT_VALID = 1 and OUT_DATA = word after E2.
- Throughput: one push and one pop per cycle sustained. With OUT_READY held high and IN_VALID high, OUT_VALID stays high every cycle after the initial 2-cycle fill.
- LEVEL and ALMOST_FULL update on the edge following the event that changes them.

## Test plan
- Single word: after reset, push 16'hA5C3 at E0 with OUT_READY = 0 -> OUT_VALID rises after E2 with OUT_DATA = 16'hA5C3, LEVEL = 1; pop one cycle -> OUT_VALID = 0, LEVEL = 0.
- Fill: OUT_READY = 0, push values 0..299 back-to-back -> exactly 258 accepted (0..257), IN_READY low from then on, LEVEL = 258, ALMOST_FULL high from LEVEL = 240; drain -> OUT_DATA sequence 0..257.
- Wrap-around: 1000 incrementing words with random IN_VALID/OUT_READY (50% each) -> output sequence 0..999 exact, RAM_RADDR never equals RAM_WADDR while RAM_RE && RAM_WE.
- Steady state: LEVEL = 100 with IN_VALID = OUT_READY = 1 for 500 cycles -> LEVEL stays 100, one word out per cycle, order preserved.
- Reset mid-operation: LEVEL = 50, assert RESETN low asynchronously between edges -> OUT_VALID, LEVEL and IN_READY go 0 immediately; after release, push 16'h1234 -> first output is 16'h1234.
- Empty pop: OUT_READY = 1 with nothing stored for 20 cycles -> OUT_VALID = 0, LEVEL = 0, RAM_RE = 0 throughout.

Source files
------------

// File: rtl/ram40_stream_fifo.sv
// First-word-fall-through stream FIFO controller around one external SB_RAM40_4K (256 x 16).
// A 2-entry output buffer absorbs the RAM's one-cycle read latency so OUT_VALID can stream every cycle.
module ram40_stream_fifo #(
  parameter int unsigned ALMOST_FULL_LVL = 240
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [15:0] IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [15:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [8:0]  LEVEL,
  output logic        ALMOST_FULL,
  output logic [10:0] RAM_WADDR,
  output logic [15:0] RAM_WDATA,
  output logic [15:0] RAM_MASK,
  output logic        RAM_WE,
  output logic        RAM_WCLKE,
  output logic [10:0] RAM_RADDR,
  output logic        RAM_RE,
  output logic        RAM_RCLKE,
  input  logic [15:0] RAM_RDATA
);

  localparam logic [8:0] AF_LVL  = 9'(ALMOST_FULL_LVL);
  localparam logic [8:0] RAM_CAP = 9'd256;

  logic [7:0]  wptr_q, wptr_d;
  logic [7:0]  rptr_q, rptr_d;
  logic [8:0]  ram_cnt_q, ram_cnt_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [15:0] obuf0_q, obuf0_d;
  logic [15:0] obuf1_q, obuf1_d;
  logic [8:0]  level_q, level_d;
  logic        af_q, af_d;

  logic        push;
  logic        pop;
  logic        rd_issue;
  logic [2:0]  ob_occ_next;
  logic [1:0]  cnt_after_pop;

  assign IN_READY  = RESETN && (ram_cnt_q != RAM_CAP);
  assign OUT_VALID = (out_cnt_q != 2'd0);
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;

  // Buffer occupancy once this cycle's pop and the pending read return have settled.
  assign ob_occ_next = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue    = RESETN && (ram_cnt_q != 9'd0) && (ob_occ_next < 3'd2);

  assign cnt_after_pop = out_cnt_q - {1'b0, pop};

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    inflight_d = rd_issue;

    if (push) begin
      wptr_d = wptr_q + 8'd1;
    end
    if (rd_issue) begin
      rptr_d = rptr_q + 8'd1;
    end

    // Pop shifts the head out first, then the returning RAM word lands in the first free slot.
    if (pop) begin
      obuf0_d = obuf1_q;
    end
    if (inflight_q) begin
      if (cnt_after_pop == 2'd0) begin
        obuf0_d = RAM_RDATA;
      end else begin
        obuf1_d = RAM_RDATA;
      end
    end

    ram_cnt_d = ram_cnt_q + {8'd0, push} - {8'd0, rd_issue};
    out_cnt_d = out_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    level_d   = ram_cnt_d + {8'd0, inflight_d} + {7'd0, out_cnt_d};
    af_d      = (level_d >= AF_LVL);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wptr_q     <= 8'd0;
      rptr_q     <= 8'd0;
      ram_cnt_q  <= 9'd0;
      inflight_q <= 1'b0;
      out_cnt_q  <= 2'd0;
      obuf0_q    <= 16'd0;
      obuf1_q    <= 16'd0;
      level_q    <= 9'd0;
      af_q       <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      out_cnt_q  <= out_cnt_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
      level_q    <= level_d;
      af_q       <= af_d;
    end
  end

  assign OUT_DATA    = obuf0_q;
  assign LEVEL       = level_q;
  assign ALMOST_FULL = af_q;

  assign RAM_WADDR = {3'b000, wptr_q};
  assign RAM_WDATA = IN_DATA;
  assign RAM_MASK  = 16'h0000;
  assign RAM_WE    = push;
  assign RAM_WCLKE = push;
  assign RAM_RADDR = {3'b000, rptr_q};
  assign RAM_RE    = rd_issue;
  assign RAM_RCLKE = rd_issue;

endmodule

// File: tb/tb_ram40_stream_fifo.sv
// Directed bench for ram40_stream_fifo with a behavioural 256 x 16 RAM in read/write mode 0.
module tb_ram40_stream_fifo;

  logic        CLK;
  logic        RESETN;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        IN_READY;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID;
  logic [8:0]  LEVEL;
  logic        ALMOST_FULL;
  logic [10:0] RAM_WADDR;
  logic [15:0] RAM_WDATA;
  logic [15:0] RAM_MASK;
  logic        RAM_WE;
  logic        RAM_WCLKE;
  logic [10:0] RAM_RADDR;
  logic        RAM_RE;
  logic        RAM_RCLKE;
  logic [15:0] ram_rdata;

  logic [15:0] mem [0:255];

  int n_chk;
  int n_err;

  ram40_stream_fifo #(.ALMOST_FULL_LVL(240)) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .IN_DATA    (in_data),
    .IN_VALID   (in_valid),
    .IN_READY   (IN_READY),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (out_ready),
    .LEVEL      (LEVEL),
    .ALMOST_FULL(ALMOST_FULL),
    .RAM_WADDR  (RAM_WADDR),
    .RAM_WDATA  (RAM_WDATA),
    .RAM_MASK   (RAM_MASK),
    .RAM_WE     (RAM_WE),
    .RAM_WCLKE  (RAM_WCLKE),
    .RAM_RADDR  (RAM_RADDR),
    .RAM_RE     (RAM_RE),
    .RAM_RCLKE  (RAM_RCLKE),
    .RAM_RDATA  (ram_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    if (RAM_WE) mem[RAM_WADDR[7:0]] <= RAM_WDATA;
    if (RAM_RE) ram_rdata <= mem[RAM_RADDR[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESETN    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    RESETN = 1'b1;
    step();
  endtask

  task automatic push_n(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      in_data  = base + 16'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int sent;
    int recv;
    int t;
    n_chk     = 0;
    n_err     = 0;
    RESETN    = 1'b0;
    in_data   = 16'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_inready", IN_READY, 0);
    chk("rst_we", RAM_WE, 0);
    do_reset();

    chk("rst_level", LEVEL, 0);
    chk("rst_ovalid", OUT_VALID, 0);
    chk("rst_af", ALMOST_FULL, 0);
    chk("rst_inready1", IN_READY, 1);
    chk("mask", RAM_MASK, 16'h0000);

    // single word: latency E0 -> E2
    in_data  = 16'hA5C3;
    in_valid = 1'b1;
    #1;
    chk("sw_we", RAM_WE, 1);
    chk("sw_wclke", RAM_WCLKE, 1);
    step();
    in_valid = 1'b0;
    chk("sw_lvl_e0", LEVEL, 1);
    chk("sw_ov_e0", OUT_VALID, 0);
    chk("sw_re_e0", RAM_RE, 1);
    step();
    chk("sw_ov_e1", OUT_VALID, 0);
    step();
    chk("sw_ov_e2", OUT_VALID, 1);
    chk("sw_data", OUT_DATA, 16'hA5C3);
    chk("sw_lvl_e2", LEVEL, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("sw_ov_pop", OUT_VALID, 0);
    chk("sw_lvl_pop", LEVEL, 0);

    // fill with 300 offered words, 258 fit
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      in_data  = 16'(i);
      in_valid = 1'b1;
      #1;
      if (IN_READY) acc++;
      step();
      chk("fill_lvl", LEVEL, acc);
      chk("fill_af", ALMOST_FULL, (acc >= 240) ? 1 : 0);
    end
    in_valid = 1'b0;
    chk("fill_acc", acc, 258);
    chk("fill_inready", IN_READY, 0);
    chk("fill_level", LEVEL, 258);

    out_ready = 1'b1;
    for (int k = 0; k < 258; k++) begin
      t = 0;
      while (!OUT_VALID && t < 8) begin
        step();
        t++;
      end
      chk("drain_vld", OUT_VALID, 1);
      chk("drain_data", OUT_DATA, k);
      step();
    end
    out_ready = 1'b0;
    step();
    chk("drain_lvl", LEVEL, 0);
    chk("drain_af", ALMOST_FULL, 0);

    // wrap-around with random handshakes
    sent = 0;
    recv = 0;
    for (int c = 0; c < 20000 && recv < 1000; c++) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      in_data   = 16'(sent);
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (OUT_VALID && out_ready) begin
        chk("wrap_data", OUT_DATA, recv);
        recv++;
      end
      if (RAM_RE && RAM_WE) chk("wrap_coll", (RAM_RADDR != RAM_WADDR) ? 1 : 0, 1);
      if (in_valid && IN_READY) sent++;
      @(posedge CLK);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("wrap_count", recv, 1000);
    step();
    chk("wrap_lvl", LEVEL, 0);

    // steady state at LEVEL 100
    push_n(100, 16'd0);
    chk("ss_lvl0", LEVEL, 100);
    for (int c = 0; c < 500; c++) begin
      in_data   = 16'(100 + c);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("ss_vld", OUT_VALID, 1);
      chk("ss_data", OUT_DATA, c);
      chk("ss_lvl", LEVEL, 100);
      @(posedge CLK);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // asynchronous reset mid-operation
    do_reset();
    push_n(50, 16'h0200);
    chk("mr_lvl50", LEVEL, 50);
    #3;
    RESETN = 1'b0;
    #1;
    chk("mr_ovalid", OUT_VALID, 0);
    chk("mr_lvl", LEVEL, 0);
    chk("mr_inready", IN_READY, 0);
    chk("mr_re", RAM_RE, 0);
    step();
    RESETN = 1'b1;
    step();
    push_n(1, 16'h1234);
    out_ready = 1'b1;
    t = 0;
    while (!OUT_VALID && t < 8) begin
      step();
      t++;
    end
    chk("mr_vld", OUT_VALID, 1);
    chk("mr_data", OUT_DATA, 16'h1234);
    step();

    // pop while empty
    for (int c = 0; c < 20; c++) begin
      chk("ep_vld", OUT_VALID, 0);
      chk("ep_lvl", LEVEL, 0);
      chk("ep_re", RAM_RE, 0);
      step();
    end
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
